// File: rtl/dom_share_mask_prng.sv
// Masked-datapath front end: splits unshared X/Y into Boolean shares and emits fresh
// randomness Z, all drawn from a seeded Fibonacci LFSR that must warm up after every seed.
module dom_share_mask_prng #(
  parameter int SHARES = 2,
  parameter int N      = 4,
  parameter int LFSR_W = 64,
  parameter int WARMUP = 16
) (
  input  logic                            ClkxCI,
  input  logic                            RstxBI,
  input  logic [LFSR_W-1:0]               SeedxDI,
  input  logic                            SeedValidxSI,
  input  logic [N-1:0]                    XxDI,
  input  logic [N-1:0]                    YxDI,
  input  logic                            InValidxSI,
  output logic                            InReadyxSO,
  output logic [N*SHARES-1:0]             _XxDO,
  output logic [N*SHARES-1:0]             _YxDO,
  output logic [N*SHARES*(SHARES-1)-1:0]  _ZxDO,
  output logic                            OutValidxSO,
  input  logic                            OutReadyxSI,
  output logic                            SeededxSO,
  output logic [1:0]                      o_dbg_state,
  output logic [LFSR_W-1:0]               o_dbg_lfsr
);

  localparam int SW = N * (SHARES - 1);
  localparam int ZW = N * SHARES * (SHARES - 1);
  localparam int R  = 2 * SW + ZW;
  localparam int CW = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [CW-1:0]       r_cnt;
  logic [N*SHARES-1:0] r_x_sh;
  logic [N*SHARES-1:0] r_y_sh;
  logic [ZW-1:0]       r_z;
  logic                r_valid;

  logic [LFSR_W-1:0]   w_lfsr_adv;
  logic [R-1:0]        w_rand;
  logic [N-1:0]        w_x0;
  logic [N-1:0]        w_y0;
  logic                w_accept;

  // Taps for x^64+x^63+x^61+x^60+1; the feedback bit enters at the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-2] ^ s[LFSR_W-4] ^ s[LFSR_W-5]};
  endfunction

  always_comb begin
    w_lfsr_adv = r_lfsr;
    w_rand     = '0;
    for (int i = 0; i < R; i++) begin
      w_rand[i]  = w_lfsr_adv[LFSR_W-1];
      w_lfsr_adv = lfsr_step(w_lfsr_adv);
    end
  end

  // Share 0 is one flat XOR of the raw operand with fresh chunks; the operand is never stored.
  always_comb begin
    w_x0 = XxDI;
    w_y0 = YxDI;
    for (int i = 0; i < SHARES - 1; i++) begin
      w_x0 = w_x0 ^ w_rand[i*N +: N];
      w_y0 = w_y0 ^ w_rand[SW + i*N +: N];
    end
  end

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, while InReadyxSO depends combinationally on OutReadyxSI.
  assign InReadyxSO = (r_state == ST_RUN) && (!r_valid || OutReadyxSI);
  assign w_accept   = InValidxSI && InReadyxSO && !SeedValidxSI;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state <= ST_UNSEEDED;
      r_lfsr  <= '0;
      r_cnt   <= '0;
      r_x_sh  <= '0;
      r_y_sh  <= '0;
      r_z     <= '0;
      r_valid <= 1'b0;
    end else begin
      if (SeedValidxSI) begin
        r_lfsr  <= (SeedxDI == '0) ? LFSR_W'(1) : SeedxDI;
        r_cnt   <= '0;
        r_state <= ST_WARMUP;
      end else begin
        case (r_state)
          ST_WARMUP: begin
            r_lfsr <= lfsr_step(r_lfsr);
            if (r_cnt == CW'(WARMUP - 1)) r_state <= ST_RUN;
            else                          r_cnt   <= r_cnt + CW'(1);
          end
          ST_RUN: if (w_accept) r_lfsr <= w_lfsr_adv;
          default: ;
        endcase
      end

      if (w_accept) begin
        r_x_sh  <= {w_rand[SW-1:0], w_x0};
        r_y_sh  <= {w_rand[2*SW-1:SW], w_y0};
        r_z     <= w_rand[R-1:2*SW];
        r_valid <= 1'b1;
      end else if (OutReadyxSI) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign _XxDO       = r_x_sh;
  assign _YxDO       = r_y_sh;
  assign _ZxDO       = r_z;
  assign OutValidxSO = r_valid;
  assign SeededxSO   = (r_state == ST_RUN);
  assign o_dbg_state = r_state;
  assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_dom_share_mask_prng.sv
// Bench for dom_share_mask_prng: a 2-share and a 3-share instance driven in lockstep
// against a cycle model with an LFSR reference and expected-output queues.
module tb_dom_share_mask_prng;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] seed = '0;
  logic        seed_valid = 1'b0;
  logic [3:0]  x = '0, y = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy2, ov2, sd2, rdy3, ov3, sd3;
  logic [7:0]  xo2, yo2, zo2;
  logic [11:0] xo3, yo3;
  logic [23:0] zo3;
  logic [1:0]  st2, st3;
  logic [63:0] lf2, lf3;

  dom_share_mask_prng #(.SHARES(2), .N(4), .LFSR_W(64), .WARMUP(16)) u_dut2 (
    .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_valid),
    .XxDI(x), .YxDI(y), .InValidxSI(in_valid), .InReadyxSO(rdy2),
    ._XxDO(xo2), ._YxDO(yo2), ._ZxDO(zo2), .OutValidxSO(ov2), .OutReadyxSI(out_ready),
    .SeededxSO(sd2), .o_dbg_state(st2), .o_dbg_lfsr(lf2)
  );

  dom_share_mask_prng #(.SHARES(3), .N(4), .LFSR_W(64), .WARMUP(16)) u_dut3 (
    .ClkxCI(clk), .RstxBI(rst_n), .SeedxDI(seed), .SeedValidxSI(seed_valid),
    .XxDI(x), .YxDI(y), .InValidxSI(in_valid), .InReadyxSO(rdy3),
    ._XxDO(xo3), ._YxDO(yo3), ._ZxDO(zo3), .OutValidxSO(ov3), .OutReadyxSI(out_ready),
    .SeededxSO(sd3), .o_dbg_state(st3), .o_dbg_lfsr(lf3)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_acc = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model
  logic [63:0] m_lfsr2, m_lfsr3;
  int          m_state = 0;
  int          m_cnt = 0;
  logic [23:0] exp_q2[$];
  logic [47:0] exp_q3[$];
  logic        hold = 1'b0;
  logic [23:0] held2;
  logic [47:0] held3;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  task automatic draw(input int r, inout logic [63:0] s, output logic [63:0] b);
    b = '0;
    for (int i = 0; i < r; i++) begin
      b[i] = s[63];
      s = lfsr_next(s);
    end
  endtask

  // One clock cycle: check and model at the falling edge, then step past the rising edge.
  task automatic tick();
    logic        exp_rdy, was_valid;
    logic [63:0] b;
    logic [3:0]  xs1, xs2, ys1, ys2;
    @(negedge clk);
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_lfsr2 = '0; m_lfsr3 = '0;
      exp_q2.delete(); exp_q3.delete(); hold = 1'b0;
    end
    exp_rdy   = (m_state == 2) && (exp_q2.size() == 0 || out_ready);
    was_valid = (exp_q2.size() != 0);
    check("in_ready2", rdy2, exp_rdy);
    check("in_ready3", rdy3, exp_rdy);
    check("out_valid2", ov2, exp_q2.size() != 0);
    check("out_valid3", ov3, exp_q3.size() != 0);
    check("seeded2", sd2, m_state == 2);
    check("seeded3", sd3, m_state == 2);
    check("state3", st3, m_state);
    check("lfsr2", lf2, m_lfsr2);
    check("lfsr3", lf3, m_lfsr3);
    if (hold) begin
      check("hold2", {xo2, yo2, zo2}, held2);
      check("hold3", {xo3, yo3, zo3}, held3);
    end
    if (exp_q2.size() != 0 && out_ready) check("data2", {xo2, yo2, zo2}, exp_q2.pop_front());
    if (exp_q3.size() != 0 && out_ready) check("data3", {xo3, yo3, zo3}, exp_q3.pop_front());
    hold  = rst_n && was_valid && !out_ready;
    held2 = {xo2, yo2, zo2};
    held3 = {xo3, yo3, zo3};
    if (rst_n && in_valid && exp_rdy && !seed_valid) begin
      n_acc++;
      draw(16, m_lfsr2, b);
      xs1 = b[3:0]; ys1 = b[7:4];
      exp_q2.push_back({xs1, x ^ xs1, ys1, y ^ ys1, b[15:8]});
      draw(40, m_lfsr3, b);
      xs1 = b[3:0]; xs2 = b[7:4]; ys1 = b[11:8]; ys2 = b[15:12];
      exp_q3.push_back({xs2, xs1, x ^ xs1 ^ xs2, ys2, ys1, y ^ ys1 ^ ys2, b[39:16]});
    end
    if (rst_n) begin
      if (seed_valid) begin
        m_lfsr2 = (seed == '0) ? 64'd1 : seed;
        m_lfsr3 = m_lfsr2;
        m_state = 1;
        m_cnt   = 0;
      end else if (m_state == 1) begin
        m_lfsr2 = lfsr_next(m_lfsr2);
        m_lfsr3 = lfsr_next(m_lfsr3);
        if (m_cnt == 15) m_state = 2;
        else             m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int cyc;

    // reset, then idle without a seed
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();

    // all-zero seed becomes 1; warmup length
    seed = '0; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    n = 0;
    while (!sd2 && n < 40) begin tick(); n++; end
    check("warmup_len", n, 16);
    check("lfsr_after_warmup", lf2, 64'h0000_0000_0001_0000);

    // directed vectors with hand-derived shares
    out_ready = 1'b1; in_valid = 1'b1; x = 4'hA; y = 4'h3;
    tick();
    check("x2_vecA", xo2, 8'h0A);
    check("y2_vecA", yo2, 8'h03);
    check("z2_vecA", zo2, 8'h00);
    check("x3_vecA", xo3, 12'h00A);
    check("x2_recomb", xo2[3:0] ^ xo2[7:4], 4'hA);
    check("y3_recomb", yo3[3:0] ^ yo3[7:4] ^ yo3[11:8], 4'h3);
    x = 4'h5; y = 4'hC;
    tick();
    check("x2_vecB", xo2, 8'h05);
    check("y2_vecB", yo2, 8'h0C);
    check("x3_vecB", xo3, 12'h80D);
    check("y3_vecB", yo3, 12'h00C);
    check("z3_vecB", zo3, 24'h0);
    in_valid = 1'b0;
    tick();

    // random traffic with downstream stalls
    n_acc = 0; cyc = 0;
    while (n_acc < 1000 && cyc < 8000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      tick();
      cyc++;
    end
    check("random_accepts", n_acc, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // reseed while an output is held
    in_valid = 1'b1; out_ready = 1'b0; x = 4'h9; y = 4'h6;
    tick();
    in_valid = 1'b0;
    seed = {$urandom(), $urandom()}; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    n = 0;
    while (!rdy2 && n < 40) begin out_ready = (n >= 4); tick(); n++; end
    check("reseed_ready_delay", n, 16);
    in_valid = 1'b1; x = 4'h7; y = 4'hE;
    tick();
    in_valid = 1'b0;
    tick();

    // seed and input in the same cycle: seed wins, nothing accepted
    seed = 64'h0123_4567_89AB_CDEF; seed_valid = 1'b1; in_valid = 1'b1;
    tick();
    seed_valid = 1'b0; in_valid = 1'b0;
    repeat (18) tick();

    // asynchronous reset while an output is pending
    in_valid = 1'b1; out_ready = 1'b0; x = 4'hF; y = 4'hF;
    tick();
    in_valid = 1'b0;
    check("pre_reset_valid", ov2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {ov2, ov3}, 2'b00);
    check("rst_data2", {xo2, yo2, zo2}, 24'h0);
    check("rst_data3", {xo3, yo3, zo3}, 48'h0);
    check("rst_ready", {rdy2, rdy3, sd2, sd3}, 4'h0);
    check("rst_state", {st2, st3}, 4'h0);
    check("rst_lfsr", lf3, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dom_share_mask_prng.md
Name: dom_share_mask_prng

Overview:
- Front end of the masked GF datapath: accepts unshared N-bit operands X and Y, splits each into SHARES Boolean shares, and emits the fresh randomness vector Z consumed by the shared square-scale-multiply stage.
- Shares and Z come from an internal seeded LFSR PRNG.
- Valid/ready handshake on input and output; one output register stage.

Parameters:
- SHARES, 2, number of Boolean shares (2 or 3).
- N, 4, operand width in bits (4 or 8).
- LFSR_W, 64, PRNG state width; requires R = 2*N*(SHARES-1) + N*SHARES*(SHARES-1) <= LFSR_W.
- WARMUP, 16, PRNG steps discarded after every (re)seed.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  asynchronous active-low reset.
- SeedxDI  in  LFSR_W  PRNG seed.
- SeedValidxSI  in  1  load SeedxDI this cycle.
- XxDI  in  N  unshared operand X.
- YxDI  in  N  unshared operand Y.
- InValidxSI  in  1  X/Y valid.
- InReadyxSO  out  1  block accepts X/Y.
- _XxDO  out  N*SHARES  shared X; share i at bits [i*N +: N].
- _YxDO  out  N*SHARES  shared Y; same packing.
- _ZxDO  out  N*SHARES*(SHARES-1)  fresh randomness for the multiplier.
- OutValidxSO  out  1  outputs valid.
- OutReadyxSI  in  1  downstream accepts.
- SeededxSO  out  1  high in RUN state.

Behaviour:
- Reset, asynchronous: state UNSEEDED; LFSR = 0; warmup counter = 0.
- Reset values of outputs: all data outputs 0; OutValidxSO = 0; InReadyxSO = 0; SeededxSO = 0.
- LFSR: Fibonacci, polynomial x^64+x^63+x^61+x^60+1 for LFSR_W = 64. One step shifts left and inserts the feedback bit at the LSB. The output bit of a step is the MSB before the shift. "Advance k" means k steps unrolled combinationally within one cycle.
- Seed load: an all-zero SeedxDI is replaced by 1.
- FSM state UNSEEDED: InReadyxSO = 0. On SeedValidxSI, load the seed, clear the counter, go to WARMUP.
- FSM state WARMUP: advance 1 step per cycle and increment the counter. When the counter reaches WARMUP-1, go to RUN, so RUN is entered WARMUP cycles after the seed cycle. InReadyxSO = 0.
- FSM state RUN: InReadyxSO = !OutValidxSO || OutReadyxSI. SeededxSO = 1.
- Accept = InValidxSI && InReadyxSO. On accept, advance R steps and take the R output bits, first bit = bit 0 of vector r.
- Mapping of r, SHARES-1 chunks of N bits each for X, then Y, then Z:
  - X shares 1..SHARES-1 = successive N-bit chunks of r.
  - X share 0 = XxDI XOR (all other X shares).
  - Y shares: next SHARES-1 chunks, same rule.
  - _ZxDO = the remaining N*SHARES*(SHARES-1) bits, in order.
- The LFSR does not advance in RUN without an accept, so no randomness is skipped or reused.
- Latency: outputs are registered and valid the cycle after accept; OutValidxSO then rises.
- Output hold: outputs stay stable while OutValidxSO && !OutReadyxSI.
- OutValidxSO clears on a downstream handshake with no new accept in the same cycle. Simultaneous handshake and accept reloads the register, and OutValidxSO stays 1.
- Reseed from any state: SeedValidxSI loads the seed and goes to WARMUP. The seed has priority over an accept in the same cycle; the input is not accepted.
- A held output stays valid through reseed until consumed.
- Reset mid-operation: outputs and state return to reset values immediately; any pending output is lost.
- Security: share 0 must be computed in one XOR level from registered-independent inputs. No unmasked X or Y value is ever stored.

Test Plan:
- Reset held, then released, no seed -> InReadyxSO = 0, OutValidxSO = 0, SeededxSO = 0 for 100 cycles.
- SeedxDI = 0, SeedValidxSI for 1 cycle -> SeededxSO rises exactly 16 cycles later. LFSR state matches a golden model seeded with 1.
- SHARES = 2, N = 4, X = 0xA, Y = 0x3, OutReadyxSI = 1:
  - share0 ^ share1 = 0xA for X and 0x3 for Y, one cycle after accept.
  - _ZxDO is 8 bits and matches the golden model.
- SHARES = 3, N = 4, 1000 random X/Y with random OutReadyxSI stalls:
  - recombined shares equal the inputs;
  - no output changes while stalled;
  - no transaction is dropped or duplicated;
  - PRNG stream matches golden (R = 40).
- Reseed while OutValidxSO = 1 and OutReadyxSI = 0:
  - held output is unchanged until consumed;
  - InReadyxSO = 0 for 16 cycles, then resumes;
  - the first post-seed random matches the golden model.
- RstxBI asserted mid-transfer with OutValidxSO = 1 -> all outputs are 0 in the same cycle (asynchronous), and the state is UNSEEDED.
